// File: rtl/stat_cnt_16.sv
// Status counter bank exposed as a 32 x 16-bit read-only register space.
// Optional cycle timestamp at addresses 8/9 is built when STAT_TIMESTAMP_EN is defined.
module stat_cnt_16 #(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic              spk_valid,
  input  logic              spk_drop,
  input  logic              frame_eof,
  input  logic              clr,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  output logic [15:0]       dout
);

  logic             clr_q;
  logic             clr_pulse;
  logic [CNT_W-1:0] sample_cnt, spk_cnt, frame_cnt;
  logic [15:0]      drop_cnt;
  logic             sample_ovf, spk_ovf, frame_ovf, drop_sat;
  logic [15:0]      sample_shd, spk_shd, frame_shd;
  logic [31:0]      a32;
  logic             lo_read;
  logic [15:0]      rd_word;

  // Shadows only ever serve hi reads, so just the zero-extended upper word is kept.
  function automatic logic [15:0] hi_word(input logic [CNT_W-1:0] v);
    return 16'(v >> 16);
  endfunction

  assign clr_pulse = clr & ~clr_q;
  assign a32       = 32'(addr);

`ifdef STAT_TIMESTAMP_EN
  logic [31:0] ts_cnt;
  logic [15:0] ts_shd;

  assign lo_read = re && (a32 == 32'd0 || a32 == 32'd2 || a32 == 32'd4 || a32 == 32'd8);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_cnt <= '0;
      ts_shd <= '0;
    end else if (clr_pulse) begin
      ts_cnt <= '0;
      ts_shd <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (lo_read) ts_shd <= ts_cnt[31:16];
    end
  end
`else
  assign lo_read = re && (a32 == 32'd0 || a32 == 32'd2 || a32 == 32'd4);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) clr_q <= 1'b0;
    else     clr_q <= clr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt <= '0;
      spk_cnt    <= '0;
      frame_cnt  <= '0;
      drop_cnt   <= '0;
      sample_ovf <= 1'b0;
      spk_ovf    <= 1'b0;
      frame_ovf  <= 1'b0;
      drop_sat   <= 1'b0;
      sample_shd <= '0;
      spk_shd    <= '0;
      frame_shd  <= '0;
    end else if (clr_pulse) begin
      sample_cnt <= '0;
      spk_cnt    <= '0;
      frame_cnt  <= '0;
      drop_cnt   <= '0;
      sample_ovf <= 1'b0;
      spk_ovf    <= 1'b0;
      frame_ovf  <= 1'b0;
      drop_sat   <= 1'b0;
      sample_shd <= '0;
      spk_shd    <= '0;
      frame_shd  <= '0;
    end else begin
      if (sample_valid) begin
        sample_cnt <= sample_cnt + CNT_W'(1);
        if (&sample_cnt) sample_ovf <= 1'b1;
      end
      if (spk_valid) begin
        spk_cnt <= spk_cnt + CNT_W'(1);
        if (&spk_cnt) spk_ovf <= 1'b1;
      end
      if (frame_eof) begin
        frame_cnt <= frame_cnt + CNT_W'(1);
        if (&frame_cnt) frame_ovf <= 1'b1;
      end
      if (spk_drop && !(&drop_cnt)) begin
        drop_cnt <= drop_cnt + 16'd1;
        if (drop_cnt == 16'hFFFE) drop_sat <= 1'b1;
      end
      // Snapshot takes pre-edge values, matching what the lo read returns.
      if (lo_read) begin
        sample_shd <= hi_word(sample_cnt);
        spk_shd    <= hi_word(spk_cnt);
        frame_shd  <= hi_word(frame_cnt);
      end
    end
  end

  always_comb begin
    rd_word = '0;
    case (a32)
      32'd0:   rd_word = sample_cnt[15:0];
      32'd1:   rd_word = sample_shd;
      32'd2:   rd_word = spk_cnt[15:0];
      32'd3:   rd_word = spk_shd;
      32'd4:   rd_word = frame_cnt[15:0];
      32'd5:   rd_word = frame_shd;
      32'd6:   rd_word = drop_cnt;
      32'd7:   rd_word = {12'b0, drop_sat, frame_ovf, spk_ovf, sample_ovf};
`ifdef STAT_TIMESTAMP_EN
      32'd8:   rd_word = ts_cnt[15:0];
      32'd9:   rd_word = ts_shd;
`endif
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     dout <= '0;
    else if (re) dout <= rd_word;
  end

endmodule

// File: tb/tb_stat_cnt_16.sv
// Self-checking bench for stat_cnt_16: vector table, directed corner sequences,
// and randomized traffic against a counting reference model.
module tb_stat_cnt_16;

  logic        clk = 1'b0;
  logic        rst, sample_valid, spk_valid, spk_drop, frame_eof, clr, re;
  logic [4:0]  addr;
  logic [15:0] dout;

  int n_cmp = 0;
  int n_bad = 0;

  stat_cnt_16 #(.CNT_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .spk_valid(spk_valid),
    .spk_drop(spk_drop), .frame_eof(frame_eof), .clr(clr), .re(re),
    .addr(addr), .dout(dout)
  );

  always #5 clk = ~clk;

  // Reference model: plain event counts and snapshot copies.
  bit [31:0] m_s, m_k, m_f, m_ss, m_ks, m_fs, m_ts, m_tss;
  bit [15:0] m_d, m_dout;
  bit        m_so, m_ko, m_fo, m_dsat, m_clrq;

  function automatic bit is_lo(input bit [4:0] a);
`ifdef STAT_TIMESTAMP_EN
    return a == 5'd0 || a == 5'd2 || a == 5'd4 || a == 5'd8;
`else
    return a == 5'd0 || a == 5'd2 || a == 5'd4;
`endif
  endfunction

  function automatic bit [15:0] word(input bit [4:0] a);
    case (a)
      5'd0: return m_s[15:0];
      5'd1: return m_ss[31:16];
      5'd2: return m_k[15:0];
      5'd3: return m_ks[31:16];
      5'd4: return m_f[15:0];
      5'd5: return m_fs[31:16];
      5'd6: return m_d;
      5'd7: return {12'b0, m_dsat, m_fo, m_ko, m_so};
`ifdef STAT_TIMESTAMP_EN
      5'd8: return m_ts[15:0];
      5'd9: return m_tss[31:16];
`endif
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_clear();
    m_s = 0; m_k = 0; m_f = 0; m_d = 0;
    m_ss = 0; m_ks = 0; m_fs = 0; m_ts = 0; m_tss = 0;
    m_so = 0; m_ko = 0; m_fo = 0; m_dsat = 0;
  endtask

  task automatic model_edge();
    bit cp;
    if (rst) begin
      model_clear();
      m_dout = 0;
      m_clrq = 0;
      return;
    end
    cp = clr && !m_clrq;
    m_clrq = clr;
    if (re) m_dout = word(addr);
    if (re && is_lo(addr)) begin
      m_ss = m_s; m_ks = m_k; m_fs = m_f; m_tss = m_ts;
    end
    if (sample_valid) begin m_s = m_s + 1; if (m_s == 0) m_so = 1; end
    if (spk_valid)    begin m_k = m_k + 1; if (m_k == 0) m_ko = 1; end
    if (frame_eof)    begin m_f = m_f + 1; if (m_f == 0) m_fo = 1; end
    if (spk_drop && m_d != 16'hFFFF) m_d = m_d + 1;
    if (m_d == 16'hFFFF) m_dsat = 1;
    m_ts = m_ts + 1;
    if (cp) model_clear();
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string name, input bit [15:0] act, input bit [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic rd(input bit [4:0] a, input bit [15:0] exp, input string name);
    re = 1; addr = a;
    step();
    re = 0;
    chk(name, dout, exp);
  endtask

  task automatic do_clr();
    clr = 1; step();
    clr = 0; step();
  endtask

  typedef struct {
    bit        re;
    bit [4:0]  addr;
    bit        s, k, d, f;
    bit [15:0] exp;
  } vec_t;
  vec_t tbl[14];

  initial begin
    tbl[0]  = '{1, 5'd7,  0, 0, 0, 0, 16'h0000};
    tbl[1]  = '{0, 5'd0,  1, 1, 1, 1, 16'h0000};
    tbl[2]  = '{0, 5'd0,  1, 1, 1, 1, 16'h0000};
    tbl[3]  = '{1, 5'd0,  1, 0, 0, 0, 16'h0002};
    tbl[4]  = '{1, 5'd1,  0, 0, 0, 0, 16'h0000};
    tbl[5]  = '{1, 5'd2,  0, 0, 0, 0, 16'h0002};
    tbl[6]  = '{1, 5'd4,  0, 0, 0, 0, 16'h0002};
    tbl[7]  = '{1, 5'd6,  0, 0, 0, 0, 16'h0002};
    tbl[8]  = '{1, 5'd3,  0, 1, 0, 0, 16'h0000};
    tbl[9]  = '{1, 5'd5,  0, 0, 0, 0, 16'h0000};
    tbl[10] = '{1, 5'd2,  0, 0, 0, 0, 16'h0003};
    tbl[11] = '{1, 5'd20, 0, 0, 0, 0, 16'h0000};
    tbl[12] = '{0, 5'd0,  0, 0, 0, 0, 16'h0000};
    tbl[13] = '{1, 5'd0,  0, 0, 0, 0, 16'h0003};

    rst = 1; sample_valid = 0; spk_valid = 0; spk_drop = 0; frame_eof = 0;
    clr = 0; re = 0; addr = '0;
    step(); step();
    rst = 0;
    chk("reset_dout", dout, 16'h0000);
    for (int a = 0; a < 8; a++) rd(5'(a), 16'h0000, $sformatf("reset_rd%0d", a));

    // Vector table
    do_clr();
    for (int i = 0; i < 14; i++) begin
      re = tbl[i].re; addr = tbl[i].addr;
      sample_valid = tbl[i].s; spk_valid = tbl[i].k;
      spk_drop = tbl[i].d; frame_eof = tbl[i].f;
      step();
      chk($sformatf("vec%0d", i), dout, tbl[i].exp);
    end
    re = 0; sample_valid = 0; spk_valid = 0; spk_drop = 0; frame_eof = 0;

    // Long sample count with concurrent drop saturation
    do_clr();
    sample_valid = 1; spk_drop = 1;
    repeat (70000) step();
    sample_valid = 0; spk_drop = 0;
    rd(5'd0, 16'h1170, "sample_lo");
    rd(5'd1, 16'h0001, "sample_hi");
    rd(5'd6, 16'hFFFF, "drop_sat_cnt");
    rd(5'd7, 16'h0008, "drop_sat_flag");
    spk_drop = 1;
    repeat (5) step();
    spk_drop = 0;
    rd(5'd6, 16'hFFFF, "drop_hold");

    // Spike counter wrap via preload
    do_clr();
    force dut.spk_cnt = 32'hFFFF_FFFE;
    step();
    release dut.spk_cnt;
    m_k = 32'hFFFF_FFFE;
    spk_valid = 1;
    repeat (3) step();
    spk_valid = 0;
    rd(5'd2, 16'h0001, "spk_wrap_lo");
    rd(5'd3, 16'h0000, "spk_wrap_hi");
    rd(5'd7, 16'h0002, "spk_ovf");

    // Clear edge with same-cycle frame and clr held high
    do_clr();
    frame_eof = 1;
    repeat (5) step();
    clr = 1;
    step();
    frame_eof = 0;
    for (int i = 0; i < 9; i++) begin
      frame_eof = (i == 2 || i == 5);
      step();
    end
    clr = 0; frame_eof = 0;
    step();
    rd(5'd4, 16'h0002, "frame_clr_edge");

    // Snapshot excludes same-cycle increment
    do_clr();
    sample_valid = 1;
    repeat (99) step();
    re = 1; addr = 5'd0;
    step();
    re = 0;
    chk("snap_lo", dout, 16'h0063);
    repeat (5) step();
    sample_valid = 0;
    rd(5'd1, 16'h0000, "snap_hi");
    rd(5'd0, 16'h0069, "snap_live");

    // Read and clear in the same cycle
    re = 1; addr = 5'd0; clr = 1;
    step();
    re = 0;
    chk("rdclr_dout", dout, 16'h0069);
    clr = 0;
    rd(5'd1, 16'h0000, "rdclr_shadow");
    rd(5'd0, 16'h0000, "rdclr_cnt");

`ifdef STAT_TIMESTAMP_EN
    do_clr();
    repeat (998) step();
    re = 1; addr = 5'd8;
    step();
    re = 0;
    n_cmp++;
    if (dout < 16'h03E7 || dout > 16'h03E8) begin
      n_bad++;
      $display("FAIL ts_lo: got %h expected 03e7..03e8", dout);
    end
    rd(5'd9, 16'h0000, "ts_hi");
`endif

    // Reset asserted mid-count forces dout to zero
    sample_valid = 1;
    repeat (20) step();
    rd(5'd0, m_s[15:0], "pre_rst_read");
    rst = 1;
    #1;
    chk("rst_async", dout, 16'h0000);
    step();
    chk("rst_held", dout, 16'h0000);
    rst = 0; sample_valid = 0;
    step();

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      sample_valid = 1'($urandom);
      spk_valid    = 1'($urandom);
      spk_drop     = 1'($urandom);
      frame_eof    = 1'($urandom);
      if ($urandom_range(0, 99) < 3) clr = ~clr;
      re   = 1'($urandom);
      addr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 9));
      step();
      chk($sformatf("rand%0d_a%0d", i, addr), dout, m_dout);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stat_cnt_16.md
Name: stat_cnt_16

Overview:
- FPGA-to-host status counter bank.
- Counts processed samples, detected spikes, completed frames and dropped spikes from the data-processing pipeline.
- Exposes the counts as a 32-word x 16-bit read-only register space on the host control-register read path (bus_clk domain), alongside the host-written control registers.
- Two-word (32-bit) counters use a lo-read snapshot, so the host always reads a coherent 32-bit value.

Parameters:
- CNT_W, 32, width of sample/spike/frame counters (legal 17..32); hi words are zero-extended above CNT_W.
- ADDR_W, 5, register address width (32 words).

Ports:
- clk  input  1  bus clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- sample_valid  input  1  one processed sample this cycle.
- spk_valid  input  1  one detected spike this cycle.
- spk_drop  input  1  one spike dropped (downstream full) this cycle.
- frame_eof  input  1  end of frame this cycle.
- clr  input  1  level from host control register; a rising edge clears all counters.
- re  input  1  host read strobe.
- addr  input  ADDR_W  host word address.
- dout  output  16  read data, registered.

Behaviour:
- Reset (async, rst=1):
  - All counters, shadows and sticky flags go to 0.
  - dout=16'h0000; clr edge-detect register=0.
- Counters:
  - sample_cnt, spk_cnt, frame_cnt are CNT_W bits wide and wrap modulo 2^CNT_W.
  - On a wrap from all-ones to 0, the matching sticky ovf flag sets.
  - drop_cnt is 16 bits and saturates at 16'hFFFF; drop_sat sets when it reaches FFFF.
  - Each counter increments by exactly 1 per cycle its input is high; inputs are independent and may all be high in the same cycle.
- Clear:
  - clr_pulse = clr & ~clr_q, where clr_q is registered clr.
  - On clr_pulse, all counters, shadows and sticky flags become 0 at the next edge.
  - Clear wins over a same-cycle increment: the counter reads 0 afterwards and the event is lost.
  - clr held high does not re-clear; only another 0->1 edge clears again.
- Register map (word addresses):
  - 0: sample lo; 1: sample hi (shadow).
  - 2: spike lo; 3: spike hi (shadow).
  - 4: frame lo; 5: frame hi (shadow).
  - 6: drop_cnt.
  - 7: status = {12'b0, drop_sat, frame_ovf, spk_ovf, sample_ovf}.
  - 8-31: read 16'h0000, except as defined under Optional Feature.
- Read timing:
  - When re=1 at edge N, dout holds the word at addr from edge N onward (1-cycle latency).
  - When re=0, dout holds its last value.
- Snapshot:
  - A read of any lo address (0, 2, 4) copies all three full counters into their shadows at that same edge.
  - A hi read returns the shadow's upper bits, not the live counter.
  - The snapshot and the lo dout take the counter value present before that edge, so a same-cycle increment is excluded from both.
  - A hi read without a prior lo read returns the last shadow (0 after reset/clear).
- Same-cycle read and clear: dout returns the pre-clear value; shadows are cleared.
- Writes: none. This block has no host write path; the write side lives in the control-register file.

Optional Feature:
- Macro: STAT_TIMESTAMP_EN.
- Defined:
  - A free-running 32-bit cycle counter ts_cnt is added; it wraps silently and is cleared by rst and clr_pulse.
  - Address 8 = ts lo (a read also snapshots ts); address 9 = ts hi shadow.
  - Any lo read (0, 2, 4, 8) snapshots all four counters together.
- Not defined: addresses 8/9 read 16'h0000 and no ts logic is synthesised.

Test Plan:
- Reset, then read addr 0..7 -> every read returns 16'h0000; dout=0 while rst=1 even mid-count.
- 70000 sample_valid pulses, read addr 0 then addr 1 -> 16'h1170 then 16'h0001.
- spk_cnt preloaded via 2^32-2 spk_valid-equivalent cycles (force), then 3 pulses, read addr 2, addr 3, addr 7 -> 16'h0001, 16'h0000, 16'h0002 (spk_ovf set).
- 65540 spk_drop pulses, read addr 6 and addr 7 -> 16'hFFFF and bit3=1; further drops leave FFFF.
- Count 5 frames; clr 0->1 in the same cycle as a frame_eof; hold clr=1 for 10 cycles with 2 more frame_eof; read addr 4 -> 16'h0002. Only the edge cleared; the same-cycle event was lost.
- Read addr 0 while sample_valid=1 at count 99 -> lo=99 (16'h0063). With the count then at 100+, read addr 1 -> shadow hi=0. With STAT_TIMESTAMP_EN, addr 8/9 after 1000 cycles from clear -> lo in 16'h03E7..16'h03E8 range per edge alignment, hi=0.
